// File: rtl/shift_lr_pkg.sv
// shift_lr_pkg: op encodings and stage partitioning helper for shift_lr_pipe
package shift_lr_pkg;
  localparam logic [1:0] OP_SRA = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;
  function automatic int stage_levels(input int width, input int stages);
    return ($clog2(width) + stages - 1) / stages;
  endfunction
endpackage

// File: rtl/shift_lr_level.sv
// shift_lr_level: one barrel-shifter mux level shifting by DIST when en is set
module shift_lr_level
  import shift_lr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic             en,
  output logic [WIDTH-1:0] res
);
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] sh;
  always_comb begin
    sra = $signed(data) >>> DIST;
    sh = op == OP_SRA ? sra :
         op == OP_SRL ? data >> DIST :
         op == OP_SLL ? data << DIST :
         {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
    res = en ? sh : data;
  end
endmodule

// File: rtl/shift_lr_pipe.sv
// shift_lr_pipe: pipelined SRA/SRL/SLL/ROL barrel shifter with valid/ready; SHIFT_LR_PIPE_FLAGS_EN adds out_zero/out_carry
module shift_lr_pipe
  import shift_lr_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_LR_PIPE_FLAGS_EN
  output logic             out_zero,
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out_data
);
  localparam int L = stage_levels(WIDTH, STAGES);
  logic             v_q     [STAGES];
  logic [WIDTH-1:0] d_q     [STAGES];
  logic [1:0]       op_q    [STAGES];
  logic [SW-1:0]    amt_q   [STAGES];
  logic             src_v   [STAGES];
  logic [WIDTH-1:0] src_d   [STAGES];
  logic [1:0]       src_op  [STAGES];
  logic [SW-1:0]    src_amt [STAGES];
  logic [WIDTH-1:0] nxt_d   [STAGES];
  logic [WIDTH-1:0] lo      [SW];
  logic             stall;
  assign stall     = v_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
`ifdef SHIFT_LR_PIPE_FLAGS_EN
  // Carry is resolved from the operand up front and rides along as a tag
  logic          c_q   [STAGES];
  logic          src_c [STAGES];
  logic          c_in;
  logic          z_q;
  logic [SW-1:0] neg_amt;
  logic [SW-1:0] dec_amt;
  assign neg_amt   = '0 - in_amt;
  assign dec_amt   = in_amt - 1'b1;
  assign c_in      = in_amt == '0 ? 1'b0 : in_op[1] ? in_data[neg_amt] : in_data[dec_amt];
  assign out_zero  = z_q;
  assign out_carry = c_q[STAGES-1];
`endif
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign src_v[s]   = in_valid;
      assign src_d[s]   = in_data;
      assign src_op[s]  = in_op;
      assign src_amt[s] = in_amt;
`ifdef SHIFT_LR_PIPE_FLAGS_EN
      assign src_c[s]   = c_in;
`endif
    end else begin : g_tail
      assign src_v[s]   = v_q[s-1];
      assign src_d[s]   = d_q[s-1];
      assign src_op[s]  = op_q[s-1];
      assign src_amt[s] = amt_q[s-1];
`ifdef SHIFT_LR_PIPE_FLAGS_EN
      assign src_c[s]   = c_q[s-1];
`endif
    end
    if (s * L < SW) begin : g_mux
      localparam int LAST = ((s + 1) * L < SW ? (s + 1) * L : SW) - 1;
      assign nxt_d[s] = lo[LAST];
    end else begin : g_pass
      assign nxt_d[s] = src_d[s];
    end
  end
  for (genvar j = 0; j < SW; j++) begin : g_lvl
    logic [WIDTH-1:0] li;
    if (j % L == 0) begin : g_first
      assign li = src_d[j/L];
    end else begin : g_next
      assign li = lo[j-1];
    end
    shift_lr_level #(.WIDTH(WIDTH), .DIST(1 << j)) u_lvl (
      .data(li),
      .op  (src_op[j/L]),
      .en  (src_amt[j/L][j]),
      .res (lo[j])
    );
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]   <= 1'b0;
        d_q[s]   <= '0;
        op_q[s]  <= OP_SRA;
        amt_q[s] <= '0;
`ifdef SHIFT_LR_PIPE_FLAGS_EN
        c_q[s]   <= 1'b0;
`endif
      end
`ifdef SHIFT_LR_PIPE_FLAGS_EN
      z_q <= 1'b0;
`endif
    end else if (!stall) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]   <= src_v[s];
        d_q[s]   <= nxt_d[s];
        op_q[s]  <= src_op[s];
        amt_q[s] <= src_amt[s];
`ifdef SHIFT_LR_PIPE_FLAGS_EN
        c_q[s]   <= src_c[s];
`endif
      end
`ifdef SHIFT_LR_PIPE_FLAGS_EN
      z_q <= nxt_d[STAGES-1] == '0;
`endif
    end
endmodule

// File: tb/tb_shift_lr_pipe.sv
// tb_shift_lr_pipe: table vectors plus scoreboard-checked sequences for shift_lr_pipe
module tb_shift_lr_pipe;
  import shift_lr_pkg::*;
  localparam int W = 32;
  localparam int S = 2;
  localparam int SW = 5;
  logic clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [W-1:0] in_data = '0, out_data;
  logic [SW-1:0] in_amt = '0;
  logic [1:0] in_op = '0;
`ifdef SHIFT_LR_PIPE_FLAGS_EN
  logic out_zero, out_carry;
`endif
  int n_chk = 0, n_pass = 0, n_pop = 0;
  typedef struct { logic [31:0] d; logic c; } exp_t;
  typedef struct { logic [1:0] op; logic [4:0] a; logic [31:0] d; logic [31:0] e; } vec_t;
  exp_t q[$];
  exp_t pend, e;
  vec_t tbl[14];
  always #5 clock = ~clock;
  shift_lr_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SHIFT_LR_PIPE_FLAGS_EN
    .out_zero(out_zero), .out_carry(out_carry),
`endif
    .out_data(out_data)
  );
  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [4:0] a, logic [31:0] d);
    logic signed [31:0] s = d;
    logic [63:0] r = {d, d} << a;
    case (op)
      OP_SRA:  return s >>> a;
      OP_SRL:  return d >> a;
      OP_SLL:  return d << a;
      default: return r[63:32];
    endcase
  endfunction
  function automatic logic carry_of(logic [1:0] op, logic [4:0] a, logic [31:0] d);
    logic [31:0] r = ref_shift(op, a, d);
    if (a == 0) return 1'b0;
    if (op == OP_ROL) return r[0];
    return op == OP_SLL ? d[32-a] : d[a-1];
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask
  always @(negedge clock) begin
    if (!reset_n) q.delete();
    else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_spurious: got result %h, want none", out_data);
        end else begin
          e = q.pop_front();
          check("sb_data", out_data, e.d);
`ifdef SHIFT_LR_PIPE_FLAGS_EN
          check("sb_zero", out_zero, e.d == 0);
          check("sb_carry", out_carry, e.c);
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(pend);
    end
  end
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d, input logic [31:0] x);
    bit acc;
    int k = 0;
    in_valid = 1'b1; in_op = op; in_amt = a; in_data = d;
    pend = '{x, carry_of(op, a, d)};
    do begin
      acc = in_ready;
      cyc();
      k++;
    end while (!acc && k < 50);
    if (!acc) begin
      n_chk++;
      $display("FAIL issue_timeout: in_ready 0 for %0d cycles, want 1", k);
    end
  endtask
  task automatic drain();
    int k = 0;
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid) && k < 60) begin
      cyc();
      k++;
    end
    check("drain", {q.size() != 0, out_valid}, 2'b00);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int c0, n0;
    logic [31:0] d, xa, xb, xc;
    tbl[0]  = '{OP_SRA, 5'd4,  32'h80000000, 32'hF8000000};
    tbl[1]  = '{OP_SRL, 5'd4,  32'h80000000, 32'h08000000};
    tbl[2]  = '{OP_SLL, 5'd31, 32'h00000001, 32'h80000000};
    tbl[3]  = '{OP_ROL, 5'd1,  32'h80000001, 32'h00000003};
    tbl[4]  = '{OP_SRA, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[5]  = '{OP_SRL, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[6]  = '{OP_SLL, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[7]  = '{OP_ROL, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[8]  = '{OP_SRA, 5'd31, 32'h7FFFFFFF, 32'h00000000};
    tbl[9]  = '{OP_SRA, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[10] = '{OP_SRL, 5'd31, 32'hFFFFFFFF, 32'h00000001};
    tbl[11] = '{OP_ROL, 5'd8,  32'h12345678, 32'h34567812};
    tbl[12] = '{OP_ROL, 5'd31, 32'h00000001, 32'h80000000};
    tbl[13] = '{OP_SLL, 5'd16, 32'h0000ABCD, 32'hABCD0000};
    repeat (3) cyc();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
`ifdef SHIFT_LR_PIPE_FLAGS_EN
    check("rst_flags", {out_zero, out_carry}, 2'b00);
`endif
    reset_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);
    issue(OP_SRA, 5'd4, 32'h80000000, 32'hF8000000);
    in_valid = 1'b0;
    check("lat_early", out_valid, 1'b0);
    cyc();
    check("lat_valid", out_valid, 1'b1);
    check("lat_data", out_data, 32'hF8000000);
    drain();
    foreach (tbl[i]) issue(tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].e);
    drain();
    c0 = n_pop;
    n0 = 0;
    for (int op = 0; op < 4; op++)
      for (int a = 0; a < 32; a++) begin
        d = $urandom;
        issue(op[1:0], a[4:0], d, ref_shift(op[1:0], a[4:0], d));
        n0++;
      end
    drain();
    check("thru_count", n_pop - c0, n0);
    xa = 32'hF0F0F0F0; xb = 32'h0000FFFF; xc = 32'h12345678;
    c0 = n_pop;
    out_ready = 1'b0;
    issue(OP_SRA, 5'd4, xa, ref_shift(OP_SRA, 5'd4, xa));
    issue(OP_SLL, 5'd8, xb, ref_shift(OP_SLL, 5'd8, xb));
    in_valid = 1'b1; in_op = OP_ROL; in_amt = 5'd12; in_data = xc;
    pend = '{ref_shift(OP_ROL, 5'd12, xc), carry_of(OP_ROL, 5'd12, xc)};
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold", {out_valid, out_data}, {1'b1, ref_shift(OP_SRA, 5'd4, xa)});
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    drain();
    check("bp_count", n_pop - c0, 3);
    c0 = n_pop;
    issue(OP_SRL, 5'd3, 32'hAAAA5555, 32'h15554AAA);
    issue(OP_SLL, 5'd3, 32'hAAAA5555, 32'h5552AAA8);
    in_valid = 1'b0;
    reset_n = 1'b0;
    cyc();
    check("rst_mid_valid", out_valid, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_stale", out_valid, 1'b0);
      cyc();
    end
    check("rst_mid_count", n_pop - c0, 0);
`ifdef SHIFT_LR_PIPE_FLAGS_EN
    issue(OP_SLL, 5'd1, 32'h80000000, 32'h00000000);
    issue(OP_SRL, 5'd1, 32'h00000003, 32'h00000001);
    drain();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
